// File: rtl/arrow_sequencer.sv
// Game-level controller for the arrow display: plays a fixed 16-step spawn
// pattern on arr and accumulates per-hit judgements into score, hits and combo.
module arrow_sequencer #(
   parameter int STEP_TICKS  = 80,
   parameter int LOOPS       = 2,
   parameter int DRAIN_TICKS = 440
) (
   input  logic       clk_arr,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic [1:0] score,
   input  logic       update,
   output logic [4:0] arr,
   output logic [9:0] total_score,
   output logic [7:0] hits,
   output logic [5:0] combo,
   output logic       playing,
   output logic       song_done,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   localparam logic [9:0] STEP_LAST  = 10'(STEP_TICKS - 1);
   localparam logic [9:0] DRAIN_LAST = 10'(DRAIN_TICKS - 1);
   localparam logic [3:0] LOOP_END   = 4'(LOOPS);

   state_t     state, state_n;
   logic [9:0] tick_cnt, tick_n;
   logic [3:0] step_idx, step_n;
   logic [3:0] loop_cnt, loop_n;
   logic [4:0] arr_n;
   logic       update_q;

   logic       adv;
   logic [9:0] cur_tick;
   logic [3:0] cur_step;
   logic [3:0] cur_loop;
   logic [2:0] ent;
   logic [10:0] score_sum;
   logic       scoring;
   logic       song_start;

   // {valid, dir}: dir 00 up, 01 down, 10 left, 11 right
   function automatic logic [2:0] pattern(input logic [3:0] idx);
      logic [2:0] e;
      case (idx)
         4'd0:    e = 3'b100;
         4'd1:    e = 3'b101;
         4'd2:    e = 3'b110;
         4'd3:    e = 3'b111;
         4'd4:    e = 3'b000;
         4'd5:    e = 3'b100;
         4'd6:    e = 3'b100;
         4'd7:    e = 3'b111;
         4'd8:    e = 3'b110;
         4'd9:    e = 3'b000;
         4'd10:   e = 3'b101;
         4'd11:   e = 3'b111;
         4'd12:   e = 3'b100;
         4'd13:   e = 3'b110;
         4'd14:   e = 3'b101;
         default: e = 3'b111;
      endcase
      return e;
   endfunction

   assign song_start = ((state == IDLE) || (state == DONE)) && start;
   assign scoring    = (state == PLAY) || (state == DRAIN);
   assign score_sum  = {1'b0, total_score} + {9'b0, score};
   assign dbg_state  = state;

   // The edge that starts a song also processes step 0, so step k of pass p
   // strobes exactly (p*16 + k)*STEP_TICKS edges after the entering edge.
   always_comb begin
      state_n  = state;
      tick_n   = tick_cnt;
      step_n   = step_idx;
      loop_n   = loop_cnt;
      arr_n    = 5'd0;
      adv      = 1'b0;
      cur_tick = tick_cnt;
      cur_step = step_idx;
      cur_loop = loop_cnt;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               adv      = 1'b1;
               cur_tick = 10'd0;
               cur_step = 4'd0;
               cur_loop = 4'd0;
               state_n  = PLAY;
            end
         end
         PLAY: adv = !pause;
         DRAIN: begin
            if (tick_cnt == DRAIN_LAST) state_n = DONE;
            else                        tick_n  = tick_cnt + 10'd1;
         end
         default: state_n = IDLE;
      endcase
      ent = pattern(cur_step);
      if (adv) begin
         if ((cur_tick == 10'd0) && (cur_loop == LOOP_END)) begin
            state_n = DRAIN;
            tick_n  = 10'd0;
         end else begin
            if ((cur_tick == 10'd0) && ent[2]) arr_n = {1'b1, 4'b0001 << ent[1:0]};
            if (cur_tick == STEP_LAST) begin
               tick_n = 10'd0;
               step_n = cur_step + 4'd1;
               loop_n = (cur_step == 4'd15) ? cur_loop + 4'd1 : cur_loop;
            end else begin
               tick_n = cur_tick + 10'd1;
               step_n = cur_step;
               loop_n = cur_loop;
            end
         end
      end
   end

   always_ff @(posedge clk_arr or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= 10'd0;
         step_idx  <= 4'd0;
         loop_cnt  <= 4'd0;
         arr       <= 5'd0;
         playing   <= 1'b0;
         song_done <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_n;
         step_idx  <= step_n;
         loop_cnt  <= loop_n;
         arr       <= arr_n;
         playing   <= (state_n == PLAY) || (state_n == DRAIN);
         song_done <= (state_n == DONE);
      end
   end

   // A held update level counts once: only its rising edge is judged.
   always_ff @(posedge clk_arr or posedge reset) begin
      if (reset) begin
         update_q    <= 1'b0;
         total_score <= 10'd0;
         hits        <= 8'd0;
         combo       <= 6'd0;
      end else begin
         update_q <= update;
         if (song_start) begin
            total_score <= 10'd0;
            hits        <= 8'd0;
            combo       <= 6'd0;
         end else if (scoring && update && !update_q) begin
            total_score <= score_sum[10] ? 10'd1023 : score_sum[9:0];
            if (score != 2'd0) begin
               if (hits != 8'd255) hits <= hits + 8'd1;
               if (combo != 6'd63) combo <= combo + 6'd1;
            end else begin
               combo <= 6'd0;
            end
         end
      end
   end

endmodule
